mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter n, default 16, meaning data/address width matching the CPU bus.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 8, meaning clock cycles per serial bit.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two).
REQ-004 SHALL have parameter BASE_ADDR, default 16'hFF00, meaning TXDATA register address; STATUS is at BASE_ADDR+2.
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port memwrite  input  1  CPU store strobe.
REQ-008 SHALL have port aluout  input  n  CPU byte address.
REQ-009 SHALL have port writedata  input  n  CPU store data.
REQ-010 SHALL have port rd_sel  output  1  high when aluout hits TXDATA or STATUS (combinational), for readdata mux.
REQ-011 SHALL have port rd_data  output  n  register read value (combinational).
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port irq  output  1  registered, high while FIFO empty and shifter idle.

Function
REQ-014 SHALL push writedata[7:0] into the FIFO when memwrite=1 and aluout=BASE_ADDR and (FIFO not full or a pop occurs the same cycle).
REQ-015 SHALL drop a TXDATA write when FIFO full with no same-cycle pop, and set sticky overflow bit.
REQ-016 SHALL clear overflow when memwrite=1, aluout=BASE_ADDR+2, writedata[3]=1; clear and new overflow in the same cycle -> overflow stays 1.
REQ-017 SHALL return on STATUS read {zeros, overflow, busy, full, empty} in bits [3:0]; TXDATA read returns {zeros, FIFO head byte}; rd_data=0 when rd_sel=0.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; if FIFO non-empty, pop head into shift register, go START at next edge.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: tx=shift[0], LSB first, each bit CLKS_PER_BIT cycles, bit counter 0..7, then STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; next byte's START begins one cycle after STOP ends (IDLE pop cycle).
REQ-023 Latency: write accepted at edge k into empty FIFO while IDLE -> tx falls at edge k+2.
REQ-024 busy SHALL be 1 in any state other than IDLE.
REQ-025 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; baud counter wraps to 0 at CLKS_PER_BIT-1.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-027 Writes to unmapped addresses SHALL have no effect.

Reset
REQ-028 While reset=1 at an edge: state=IDLE, FIFO emptied, overflow=0, counters=0, tx=1, irq=1 after that edge.
REQ-029 Reset mid-frame SHALL abort the frame; tx=1 from the next edge; queued bytes discarded.
REQ-030 rd_data SHALL reflect reset values (STATUS=4'b0001) after reset.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum and register offset constants (TXDATA_OFS=0, STATUS_OFS=2, status bit indices).
REQ-032 FIFO SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-033 Shifter FSM, baud counter, address decode SHALL live in mmio_uart_tx.

Verification
REQ-034 Reset, then write 8'h55 to 16'hFF00 -> tx bits 0,1,0,1,0,1,0,1,0,1 each 8 cycles; irq high after 80 cycles.
REQ-035 Five back-to-back writes 8'h01..8'h05 while idle -> all five transmitted in order (first pops immediately), STATUS overflow=0.
REQ-036 Six back-to-back writes with shifter busy -> sixth dropped, STATUS reads 4'b1110 (overflow, busy, full); write 16'h0008 to 16'hFF02 -> overflow=0.
REQ-037 Assert reset at cycle 30 of a frame -> tx=1 next cycle, STATUS=4'b0001, no further frames.
REQ-038 Write 8'hAA to 16'hFF04 (unmapped) -> tx stays 1, rd_sel=0, FIFO empty.
REQ-039 Read STATUS with aluout=16'hFF02 when idle -> rd_sel=1, rd_data=16'h0001.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - uart_state_t : states of the serial shifter FSM
//   - TXDATA_OFS / STATUS_OFS : register offsets from the peripheral base
//   - ST_*_BIT : bit positions of the flags inside the STATUS register
// ---------------------------------------------------------------------------
package uart_pkg;

    // Shifter FSM: wait for data, then start bit, eight data bits, stop bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int TXDATA_OFS = 0;
    localparam int STATUS_OFS = 2;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through output (dout always shows
// the head entry). A push into a full FIFO is accepted only when a pop happens
// in the same cycle; a pop from an empty FIFO is ignored.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   push, din     : write strobe and data
//   pop           : remove head entry
//   dout          : head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    // A pop only counts when there is something to remove; a push into a full
    // FIFO is allowed when the head is leaving in the same cycle, because the
    // freed slot is exactly the one being written.
    always_comb begin
        doPop  = pop && !empty;
        doPush = push && (!full || doPop);
    end

    // Flags and head output are derived straight from the stored state.
    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
        dout  = mem[rdPtr];
    end

    // Storage array is not reset; only entries between the pointers are
    // meaningful, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers wrap explicitly at DEPTH-1 so the FIFO also behaves for a depth
    // of one, where the pointer width does not match the entry count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= (rdPtr == AW'(DEPTH - 1)) ? '0 : rdPtr + AW'(1);
            end
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter for the CPU bus. Stores to TXDATA queue a byte
// in a small FIFO; a shifter FSM sends each byte as 8N1 (start bit, LSB-first
// data, stop bit), CLKS_PER_BIT clocks per bit. STATUS reports
// {overflow, busy, full, empty}; writing STATUS with bit 3 set clears overflow.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   memwrite            : CPU store strobe
//   aluout              : CPU byte address
//   writedata           : CPU store data
//   rd_sel              : address hits one of the two registers
//   rd_data             : read value of the addressed register (0 if unmapped)
//   tx                  : serial line, idle high
//   irq                 : high while FIFO empty and shifter idle
// ---------------------------------------------------------------------------
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int             n            = 16,
    parameter int             CLKS_PER_BIT = 8,
    parameter int             FIFO_DEPTH   = 4,
    parameter logic [n-1:0]   BASE_ADDR    = 16'hFF00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [n-1:0] aluout,
    input  logic [n-1:0] writedata,
    output logic         rd_sel,
    output logic [n-1:0] rd_data,
    output logic         tx,
    output logic         irq
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [n-1:0] TXDATA_ADDR = BASE_ADDR + n'(TXDATA_OFS);
    localparam logic [n-1:0] STATUS_ADDR = BASE_ADDR + n'(STATUS_OFS);

    uart_state_t   state;
    logic [BW-1:0] baudCnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          overflow;

    logic          txdataHit;
    logic          statusHit;
    logic          fifoPush;
    logic          fifoPop;
    logic          overflowSet;
    logic          overflowClr;
    logic          baudDone;
    logic          busy;
    logic          idleNext;
    logic          fifoEmptyNext;

    logic [7:0]    fifoDout;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;

    // Address decode and the write-side control. The shifter takes the FIFO
    // head on any idle cycle where data is waiting, and that same pop is what
    // lets a write into a full FIFO still be accepted.
    always_comb begin
        txdataHit   = (aluout == TXDATA_ADDR);
        statusHit   = (aluout == STATUS_ADDR);
        fifoPop     = (state == IDLE) && !fifoEmpty;
        fifoPush    = memwrite && txdataHit && (!fifoFull || fifoPop);
        overflowSet = memwrite && txdataHit && fifoFull && !fifoPop;
        overflowClr = memwrite && statusHit && writedata[3];
        baudDone    = (baudCnt == BW'(CLKS_PER_BIT - 1));
        busy        = (state != IDLE);
    end

    // Look ahead one edge so irq, although registered, tracks "FIFO empty and
    // shifter idle" without an extra cycle of lag.
    always_comb begin
        idleNext      = ((state == IDLE) && fifoEmpty) || ((state == STOP) && baudDone);
        fifoEmptyNext = ((fifoCount + CW'(fifoPush)) == CW'(fifoPop));
    end

    // Register read mux: STATUS flags in the low nibble, TXDATA shows the byte
    // that will be sent next, anything else reads as zero.
    always_comb begin
        rd_sel  = txdataHit || statusHit;
        rd_data = '0;
        if (statusHit) begin
            rd_data[ST_EMPTY_BIT] = fifoEmpty;
            rd_data[ST_FULL_BIT]  = fifoFull;
            rd_data[ST_BUSY_BIT]  = busy;
            rd_data[ST_OVF_BIT]   = overflow;
        end else if (txdataHit) begin
            rd_data[7:0] = fifoDout;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (writedata[7:0]),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Sticky overflow flag. A dropped write wins over a clear in the same
    // cycle so a fresh overflow is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (overflowSet) begin
            overflow <= 1'b1;
        end else if (overflowClr) begin
            overflow <= 1'b0;
        end
    end

    // Shifter FSM with baud and bit counters. tx is registered from the
    // current state, so the line follows the state one cycle later: the start
    // bit appears the cycle after the pop, and every bit, including the stop
    // bit, lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    baudCnt <= '0;
                    bitCnt  <= '0;
                    if (!fifoEmpty) begin
                        shiftReg <= fifoDout;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baudDone) begin
                        baudCnt <= '0;
                        state   <= DATA;
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                DATA: begin
                    tx <= shiftReg[0];
                    if (baudDone) begin
                        baudCnt  <= '0;
                        shiftReg <= {1'b0, shiftReg[7:1]};
                        if (bitCnt == 3'd7) begin
                            bitCnt <= '0;
                            state  <= STOP;
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                        end
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baudDone) begin
                        baudCnt <= '0;
                        state   <= IDLE;
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Interrupt request: the transmitter has nothing left to do.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b1;
        end else begin
            irq <= idleNext && fifoEmptyNext;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
// Directed self-checking bench for mmio_uart_tx with default parameters
// (n=16, 8 clocks per bit, 4-entry FIFO, base 16'hFF00). A background monitor
// decodes frames from tx into a queue; the main sequence drives bus writes,
// reads registers and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [15:0] aluout;
    logic [15:0] writedata;
    logic        rd_sel;
    logic [15:0] rd_data;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic       monEnable = 1'b0;
    logic [7:0] monByte;
    logic       monOk;
    logic [7:0] rxQ[$];
    logic       rxOkQ[$];

    mmio_uart_tx #(
        .n            (16),
        .CLKS_PER_BIT (8),
        .FIFO_DEPTH   (4),
        .BASE_ADDR    (16'hFF00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .tx        (tx),
        .irq       (irq)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Frame monitor: on a falling tx it samples mid-bit for the start bit,
    // eight data bits LSB first and the stop bit, then queues the byte and
    // whether the framing bits were correct.
    initial begin
        forever begin
            @(negedge clk);
            if (monEnable && tx == 1'b0) begin
                monOk = 1'b1;
                repeat (4) @(negedge clk);
                if (tx !== 1'b0) monOk = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    monByte[i] = tx;
                end
                repeat (8) @(negedge clk);
                if (tx !== 1'b1) monOk = 1'b0;
                rxQ.push_back(monByte);
                rxOkQ.push_back(monOk);
            end
        end
    end

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
        memwrite  = 1'b1;
        aluout    = addr;
        writedata = data;
        step(1);
        memwrite  = 1'b0;
        aluout    = 16'h0000;
        writedata = 16'h0000;
    endtask

    task automatic readReg(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        aluout = addr;
        #1;
        checkOutput(tag, 32'(rd_data), 32'(exp));
        aluout = 16'h0000;
        #1;
    endtask

    task automatic checkFrames(input string tag, input logic [7:0] first, input int count, input int budget);
        int waited = 0;
        while (rxQ.size() < count && waited < budget) begin
            step(1);
            waited++;
        end
        checkOutput($sformatf("%s_frames", tag), 32'(rxQ.size()), 32'(count));
        for (int i = 0; i < count; i++) begin
            if (rxQ.size() > 0) begin
                checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rxQ.pop_front()), 32'(first) + 32'(i));
                checkOutput($sformatf("%s_framing%0d", tag, i), 32'(rxOkQ.pop_front()), 32'd1);
            end
        end
    endtask

    initial begin
        logic [9:0] expBits;
        int lowCount;

        reset     = 1'b1;
        memwrite  = 1'b0;
        aluout    = 16'h0000;
        writedata = 16'h0000;
        step(3);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_irq", 32'(irq), 32'd1);
        readReg("reset_status", 16'hFF02, 16'h0001);
        reset = 1'b0;
        step(1);
        monEnable = 1'b1;

        $display("[TB] register decode while idle");
        aluout = 16'hFF02;
        #1;
        checkOutput("status_rd_sel", 32'(rd_sel), 32'd1);
        checkOutput("status_rd_data", 32'(rd_data), 32'h0001);
        aluout = 16'hFF00;
        #1;
        checkOutput("txdata_rd_sel", 32'(rd_sel), 32'd1);
        aluout = 16'hFF04;
        #1;
        checkOutput("unmapped_rd_sel", 32'(rd_sel), 32'd0);
        checkOutput("unmapped_rd_data", 32'(rd_data), 32'h0000);
        aluout = 16'h0000;

        $display("[TB] single byte 0x55 bit timing");
        applyStimulus(16'hFF00, 16'h0055);
        checkOutput("irq_low_after_write", 32'(irq), 32'd0);
        step(1);
        checkOutput("tx_high_k1", 32'(tx), 32'd1);
        readReg("status_start", 16'hFF02, 16'h0005);
        step(1);
        checkOutput("tx_low_k2", 32'(tx), 32'd0);
        expBits = 10'b1010101010;
        step(4);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bit55_%0d", i), 32'(tx), 32'(expBits[i]));
            step(8);
        end
        checkOutput("irq_after_frame", 32'(irq), 32'd1);
        readReg("status_after_frame", 16'hFF02, 16'h0001);
        checkFrames("b55", 8'h55, 1, 50);

        $display("[TB] five back-to-back bytes while idle");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(16'hFF00, 16'(i));
        end
        readReg("status_five", 16'hFF02, 16'h0006);
        checkFrames("five", 8'h01, 5, 600);
        step(10);
        readReg("status_five_done", 16'hFF02, 16'h0001);
        checkOutput("irq_five_done", 32'(irq), 32'd1);

        $display("[TB] six writes with shifter busy");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'hFF00, 16'h0010 + 16'(i));
        end
        readReg("status_overflow", 16'hFF02, 16'h000E);
        readReg("txdata_head", 16'hFF00, 16'h0011);
        applyStimulus(16'hFF02, 16'h0007);
        readReg("status_no_clear", 16'hFF02, 16'h000E);
        applyStimulus(16'hFF02, 16'h0008);
        readReg("status_cleared", 16'hFF02, 16'h0006);
        checkFrames("six", 8'h10, 5, 600);
        step(10);
        readReg("status_six_done", 16'hFF02, 16'h0001);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(16'hFF00, 16'h00C3);
        applyStimulus(16'hFF00, 16'h003C);
        applyStimulus(16'hFF00, 16'h0099);
        step(29);
        reset = 1'b1;
        step(1);
        checkOutput("abort_tx", 32'(tx), 32'd1);
        checkOutput("abort_irq", 32'(irq), 32'd1);
        readReg("abort_status", 16'hFF02, 16'h0001);
        reset = 1'b0;
        lowCount = 0;
        for (int i = 0; i < 250; i++) begin
            step(1);
            if (tx == 1'b0) lowCount++;
            if (i == 150) begin
                rxQ.delete();
                rxOkQ.delete();
            end
        end
        checkOutput("abort_tx_low_cycles", 32'(lowCount), 32'd0);
        checkOutput("abort_no_frames", 32'(rxQ.size()), 32'd0);

        $display("[TB] write to unmapped address");
        applyStimulus(16'hFF04, 16'h00AA);
        aluout = 16'hFF04;
        #1;
        checkOutput("unmapped_write_rd_sel", 32'(rd_sel), 32'd0);
        aluout = 16'h0000;
        lowCount = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tx == 1'b0) lowCount++;
        end
        checkOutput("unmapped_tx_low_cycles", 32'(lowCount), 32'd0);
        readReg("unmapped_status", 16'hFF02, 16'h0001);
        checkOutput("unmapped_irq", 32'(irq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
